// File: rtl/parser_ctrl_if.sv
// Signal bundle between the L2 parser sequencer and its surroundings: ingress stream,
// byte-position counter strobes, header capture/handshake and frame statistics.
interface parser_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic                 ctr_frame_start;
  logic                 ctr_beat;
  logic                 ctr_header_done;
  logic                 hdr_capture;
  logic                 hdr_valid;
  logic                 hdr_ready;
  logic                 runt_err;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] runt_cnt;

  // Sequencer view
  modport slave (
    input  s_valid, s_last, ctr_header_done, hdr_ready,
    output s_ready, ctr_frame_start, ctr_beat, hdr_capture, hdr_valid,
           runt_err, frame_cnt, runt_cnt
  );

  // Environment view (ingress source, counter, classifier)
  modport master (
    output s_valid, s_last, ctr_header_done, hdr_ready,
    input  s_ready, ctr_frame_start, ctr_beat, hdr_capture, hdr_valid,
           runt_err, frame_cnt, runt_cnt
  );
endinterface

// File: rtl/parser_ctrl.sv
// Frame-level sequencer for the L2 parser front end: qualifies ingress beats, drives the
// byte-position counter and header capture, hands the header downstream, counts frames/runts.
module parser_ctrl #(
  parameter int DATA_WIDTH          = 64,
  parameter int L2_HEADER_MAX_BYTES = 18,
  parameter int CNT_WIDTH           = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  parser_ctrl_if.slave bus
);

  if (((DATA_WIDTH % 8) != 0) || (L2_HEADER_MAX_BYTES < 1) || (CNT_WIDTH < 1)) begin : g_param_check
    $error("parser_ctrl: illegal parameterisation");
  end

  localparam logic [1:0] S_HDR   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_PAY   = 2'd2;
  localparam logic [1:0] S_START = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic                 last_seen_r;
  logic                 last_seen_nxt_s;
  logic                 hdr_valid_r;
  logic                 hdr_valid_nxt_s;
  logic                 runt_err_r;
  logic                 runt_err_nxt_s;
  logic [CNT_WIDTH-1:0] frame_cnt_r;
  logic [CNT_WIDTH-1:0] frame_cnt_nxt_s;
  logic [CNT_WIDTH-1:0] runt_cnt_r;
  logic [CNT_WIDTH-1:0] runt_cnt_nxt_s;
  logic                 s_ready_s;
  logic                 acc_s;
  logic                 hdr_beat_s;

  // Ingress is only taken while parsing header or payload; HOLD and START backpressure it
  assign s_ready_s  = (state_r == S_HDR) || (state_r == S_PAY);
  assign acc_s      = bus.s_valid & s_ready_s;
  assign hdr_beat_s = acc_s & (state_r == S_HDR);

  // Next-state and statistics decode
  always_comb begin
    state_nxt_s     = state_r;
    last_seen_nxt_s = last_seen_r;
    hdr_valid_nxt_s = hdr_valid_r;
    runt_err_nxt_s  = 1'b0;
    frame_cnt_nxt_s = frame_cnt_r;
    runt_cnt_nxt_s  = runt_cnt_r;
    case (state_r)
      S_HDR: begin
        if (acc_s && bus.ctr_header_done) begin
          hdr_valid_nxt_s = 1'b1;
          last_seen_nxt_s = bus.s_last;
          state_nxt_s     = S_HOLD;
          if (bus.s_last) begin
            frame_cnt_nxt_s = frame_cnt_r + CNT_ONE;
          end else begin
            frame_cnt_nxt_s = frame_cnt_r;
          end
        end else if (acc_s && bus.s_last) begin
          // Frame ended before the header window filled
          runt_err_nxt_s = 1'b1;
          runt_cnt_nxt_s = runt_cnt_r + CNT_ONE;
          state_nxt_s    = S_START;
        end else begin
          state_nxt_s = S_HDR;
        end
      end
      S_HOLD: begin
        if (bus.hdr_ready) begin
          hdr_valid_nxt_s = 1'b0;
          if (last_seen_r) begin
            state_nxt_s = S_START;
          end else begin
            state_nxt_s = S_PAY;
          end
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      S_PAY: begin
        if (acc_s && bus.s_last) begin
          frame_cnt_nxt_s = frame_cnt_r + CNT_ONE;
          state_nxt_s     = S_START;
        end else begin
          state_nxt_s = S_PAY;
        end
      end
      S_START: begin
        state_nxt_s = S_HDR;
      end
      default: begin
        // Unreachable encoding: drop any pending header and restart cleanly
        state_nxt_s     = S_START;
        hdr_valid_nxt_s = 1'b0;
        last_seen_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_HDR;
      last_seen_r <= 1'b0;
      hdr_valid_r <= 1'b0;
      runt_err_r  <= 1'b0;
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      runt_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      last_seen_r <= last_seen_nxt_s;
      hdr_valid_r <= hdr_valid_nxt_s;
      runt_err_r  <= runt_err_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      runt_cnt_r  <= runt_cnt_nxt_s;
    end
  end

  assign bus.s_ready         = s_ready_s;
  assign bus.ctr_beat        = hdr_beat_s;
  assign bus.hdr_capture     = hdr_beat_s;
  assign bus.ctr_frame_start = (state_r == S_START);
  assign bus.hdr_valid       = hdr_valid_r;
  assign bus.runt_err        = runt_err_r;
  assign bus.frame_cnt       = frame_cnt_r;
  assign bus.runt_cnt        = runt_cnt_r;

endmodule

// File: tb/tb_parser_ctrl.sv
// Scoreboard bench for parser_ctrl: directed frames push expected events, a negedge
// monitor pops and checks them; the byte-position counter is modelled locally.
module tb_parser_ctrl;

  localparam int K_HDR   = 0;
  localparam int K_RUNT  = 1;
  localparam int K_START = 2;

  typedef struct {
    int kind;
    int beats;
    int fcnt;
    int rcnt;
    int stall;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   exp_frame;
  int   exp_runt;
  exp_t q[$];

  bit   ready_force;
  int   ready_delay;
  int   hold_n;
  int   pos;

  int   beat_n;
  int   cap_n;
  int   stall_n;
  bit   prev_hv;

  parser_ctrl_if #(.CNT_WIDTH(32)) ifc ();

  parser_ctrl #(
    .DATA_WIDTH(64),
    .L2_HEADER_MAX_BYTES(18),
    .CNT_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-position counter model: 8 bytes per beat, header window of 18 bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= 0;
    else if (ifc.ctr_frame_start) pos <= 0;
    else if (ifc.ctr_beat) pos <= pos + 8;
  end
  assign ifc.ctr_header_done = ((pos + 8) >= 18);

  // Downstream classifier: accepts after ready_delay cycles of hdr_valid, or always when forced
  always @(posedge clk) begin
    #1;
    if (ifc.hdr_valid) begin
      ifc.hdr_ready = ready_force || (hold_n >= ready_delay);
      hold_n++;
    end else begin
      ifc.hdr_ready = ready_force;
      hold_n = 0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input int kind, output exp_t e, output bit ok);
    tests++;
    ok = 1'b0;
    e  = '{-1, 0, 0, 0, 0};
    if (q.size() == 0) begin
      fails++;
      $display("FAIL event_order: got event kind %0d, expected no event", kind);
    end else begin
      e = q.pop_front();
      if (e.kind != kind) begin
        fails++;
        $display("FAIL event_order: got event kind %0d, expected kind %0d", kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: tallies per-frame activity and checks each DUT event against the queue
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst_n) begin
      beat_n  = 0;
      cap_n   = 0;
      stall_n = 0;
      prev_hv = 1'b0;
    end else begin
      if (ifc.ctr_beat) beat_n++;
      if (ifc.hdr_capture) cap_n++;
      if (!ifc.s_ready) stall_n++;
      if (ifc.hdr_valid && !prev_hv) begin
        pop_check(K_HDR, e, ok);
        if (ok) begin
          chk("hdr_rise_beats", beat_n, e.beats);
          chk("hdr_rise_frame_cnt", ifc.frame_cnt, e.fcnt);
        end
      end
      if (ifc.runt_err) begin
        pop_check(K_RUNT, e, ok);
        if (ok) chk("runt_cnt_at_pulse", ifc.runt_cnt, e.rcnt);
      end
      if (ifc.ctr_frame_start) begin
        pop_check(K_START, e, ok);
        if (ok) begin
          chk("frame_beats", beat_n, e.beats);
          chk("frame_captures", cap_n, e.beats);
          chk("frame_cnt", ifc.frame_cnt, e.fcnt);
          chk("runt_cnt", ifc.runt_cnt, e.rcnt);
          chk("stall_cycles", stall_n, e.stall);
        end
        beat_n  = 0;
        cap_n   = 0;
        stall_n = 0;
      end
      prev_hv = ifc.hdr_valid;
    end
  end

  task automatic expect_good(input int n, input int hold);
    exp_frame++;
    q.push_back('{K_HDR, 3, (n == 3) ? exp_frame : exp_frame - 1, exp_runt, 0});
    q.push_back('{K_START, 3, exp_frame, exp_runt, hold + 1});
  endtask

  task automatic expect_runt(input int n);
    exp_runt++;
    q.push_back('{K_RUNT, n, exp_frame, exp_runt, 0});
    q.push_back('{K_START, n, exp_frame, exp_runt, 1});
  endtask

  task automatic wait_accept();
    bit took;
    int guard;
    took  = 1'b0;
    guard = 0;
    while (!took) begin
      took = ifc.s_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!took && guard > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got s_ready low for %0d cycles, expected acceptance", guard);
        took = 1'b1;
      end
    end
  endtask

  // Send n beats; gaps bit i inserts one idle cycle before beat i
  task automatic send_frame(input int n, input int gaps, input bit last_en);
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
        @(posedge clk);
        #1;
      end
      ifc.s_valid = 1'b1;
      ifc.s_last  = last_en && (i == n - 1);
      wait_accept();
    end
  endtask

  task automatic idle(input int n);
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hdr_valid"}, ifc.hdr_valid, 0);
    chk({tag, "_runt_err"}, ifc.runt_err, 0);
    chk({tag, "_ctr_frame_start"}, ifc.ctr_frame_start, 0);
    chk({tag, "_ctr_beat"}, ifc.ctr_beat, 0);
    chk({tag, "_hdr_capture"}, ifc.hdr_capture, 0);
    chk({tag, "_frame_cnt"}, ifc.frame_cnt, 0);
    chk({tag, "_runt_cnt"}, ifc.runt_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    tests       = 0;
    fails       = 0;
    exp_frame   = 0;
    exp_runt    = 0;
    ready_force = 1'b0;
    ready_delay = 0;
    hold_n      = 0;
    rst_n       = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // 8-beat frame with hdr_ready tied high
    ready_force = 1'b1;
    expect_good(8, 1);
    send_frame(8, 0, 1'b1);
    idle(4);
    ready_force = 1'b0;

    // Runt then a normal 4-beat frame
    expect_runt(2);
    send_frame(2, 0, 1'b1);
    idle(3);
    expect_good(4, 1);
    send_frame(4, 0, 1'b1);
    idle(3);

    // Exact 3-beat frame with a 5-cycle downstream stall
    ready_delay = 5;
    expect_good(3, 6);
    send_frame(3, 0, 1'b1);
    idle(12);
    ready_delay = 0;

    // Reset asserted while in payload
    q.push_back('{K_HDR, 3, exp_frame, exp_runt, 0});
    send_frame(5, 0, 1'b0);
    ifc.s_valid = 1'b0;
    chk("pre_reset_frame_cnt", ifc.frame_cnt, 3);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midframe_reset");
    chk("pending_before_reset", q.size(), 0);
    q.delete();
    exp_frame = 0;
    exp_runt  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Fresh frame after reset
    expect_good(4, 1);
    send_frame(4, 0, 1'b1);
    idle(3);

    // Ten back-to-back 4-beat frames, s_valid held high throughout
    for (int f = 0; f < 10; f++) expect_good(4, 1);
    for (int f = 0; f < 10; f++) send_frame(4, 0, 1'b1);
    idle(4);
    chk("b2b_frame_cnt", ifc.frame_cnt, 11);

    // s_valid gaps inside the header window
    expect_good(5, 1);
    send_frame(5, 6, 1'b1);
    idle(3);
    expect_good(4, 1);
    send_frame(4, 5, 1'b1);
    idle(10);

    chk("final_frame_cnt", ifc.frame_cnt, 13);
    chk("final_runt_cnt", ifc.runt_cnt, 0);
    chk("unconsumed_events", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parser_ctrl.md
Name: parser_ctrl

Overview:
- Frame-level sequencer for the L2 parser front end; sits between the ingress AXI-Stream slave and the byte-position counter / header capture logic.
- Qualifies beats, drives the counter's clear and advance strobes, and gates header-capture register enables.
- Presents the completed L2 header to the downstream classifier with a valid/ready handshake, stalling ingress until it is taken.
- Detects runt frames (frame ends before the header completes) and keeps good-frame and runt statistics.

Parameters:
- DATA_WIDTH, 64: ingress beat width in bits; must be a multiple of 8. BYTES_PER_BEAT = DATA_WIDTH/8.
- L2_HEADER_MAX_BYTES, 18: header window length in bytes.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  ingress beat valid
- s_last  in  1  ingress last beat of frame
- s_ready  out  1  ingress ready
- ctr_frame_start  out  1  counter clear strobe
- ctr_beat  out  1  counter advance strobe
- ctr_header_done  in  1  counter says the position after the current beat is >= L2_HEADER_MAX_BYTES
- hdr_capture  out  1  header shift/capture enable for the current beat
- hdr_valid  out  1  captured header available downstream
- hdr_ready  in  1  downstream accepts header
- runt_err  out  1  one-cycle pulse on runt detection
- frame_cnt  out  CNT_WIDTH  good frames completed
- runt_cnt  out  CNT_WIDTH  runt frames seen

Behaviour:
- Reset values: state S_HDR; last_seen=0; all single-bit outputs 0; frame_cnt=0; runt_cnt=0. Reset asynchronous on rst_n low; reset mid-frame abandons the frame and takes no further action.
- acc = s_valid & s_ready (combinational).
- s_ready = 1 in S_HDR and S_PAY; 0 in S_HOLD and S_START.
- ctr_beat = acc & (state==S_HDR). The counter freezes once the header is complete, so it never wraps in the payload.
- hdr_capture = ctr_beat.
- The counter's frame_end input is tied low at integration.
- States and transitions:
  - S_HDR, acc & ctr_header_done:
    - set hdr_valid (registered, high from the next cycle);
    - last_seen <= s_last;
    - if s_last, frame_cnt++;
    - -> S_HOLD.
  - S_HDR, acc & !ctr_header_done & s_last:
    - runt_err pulses high the next cycle for exactly 1 cycle;
    - runt_cnt++;
    - -> S_START.
  - S_HDR, otherwise: stay.
  - S_HOLD: hdr_valid=1 and stable. On hdr_ready:
    - hdr_valid <= 0;
    - -> S_START if last_seen, else -> S_PAY.
  - S_PAY, acc & s_last: frame_cnt++, -> S_START. Other payload beats: stay.
  - S_START: ctr_frame_start=1 for exactly this cycle (Moore output). Unconditionally -> S_HDR.
- Latency:
  - hdr_valid rises 1 cycle after the header-completing beat is accepted.
  - Minimum inter-frame bubble: 1 cycle (S_START).
  - Ingress stall while in S_HOLD equals the downstream hdr_ready latency.
- The runt_err pulse and the hdr_valid rise are never concurrent.
- hdr_valid must not drop without hdr_ready.
- hdr_ready while hdr_valid=0 is ignored.
- s_valid high in S_HOLD or S_START: the beat is not accepted; it must be held by the source (AXI rules).
- Statistics counters wrap modulo 2^CNT_WIDTH and update 1 cycle after the triggering event.
- Header beats for defaults: positions 0→8→16→24; ctr_header_done is asserted on the 3rd header beat.

Test Plan:
- 8-beat frame (DATA_WIDTH=64), hdr_ready tied 1:
  - ctr_beat/hdr_capture on beats 1-3 only;
  - hdr_valid high 1 cycle after beat 3; s_ready low 1 cycle;
  - beats 4-8 accepted in S_PAY;
  - after beat 8: ctr_frame_start pulses once, frame_cnt=1, runt_cnt=0.
- 2-beat frame (s_last on beat 2):
  - runt_err single pulse, runt_cnt=1, hdr_valid never asserts;
  - ctr_frame_start the next cycle;
  - a following 4-beat frame parses normally (frame_cnt=1).
- Exact 3-beat frame (s_last on beat 3), hdr_ready held 0 for 5 cycles:
  - hdr_valid stays high and s_ready low for those 5 cycles;
  - on hdr_ready: S_START, ctr_frame_start pulse, frame_cnt=1.
- Back-to-back 4-beat frames with s_valid always 1 and hdr_ready=1:
  - exactly 1 S_HOLD stall plus 1 S_START bubble per frame;
  - frame_cnt=10 after 10 frames.
- rst_n asserted low in S_PAY mid-frame (frame_cnt=3):
  - all outputs return to reset values asynchronously, counters read 0;
  - a fresh 4-beat frame after release parses with ctr_beat on its first 3 beats.
- Random s_valid gaps in the header:
  - ctr_beat only on accepted beats;
  - hdr_valid still rises after exactly the 3rd accepted beat.
